user_data_check: RTL and testbench
==================================

# user_data_check

Receive-side checker for the Aurora 8B/10B user interface. It sits directly downstream of the Aurora core's RX AXI-Stream port, alongside the TX pattern generator. It verifies that each received frame carries the generator's pattern: data 0,1,2,… restarting at 0 every frame, with a fixed length. It reports per-beat and per-frame errors, saturating frame and error counters, and a link-ok flag for board bring-up and ILA observation.

## Interface
- P_FRAME_LEN, 100: expected beats per frame, 2..65535.
- P_LOCK_FRAMES, 2: consecutive good frames required to assert o_link_ok, 1..255.
- i_clk  in  1  user clock of the Aurora core.
- i_rst  in  1  reset, asynchronous, active-high; clock i_clk.
- i_clr  in  1  synchronous clear of counters and link flag.
- s_axi_rx_tdata  in  32  received data.
- s_axi_rx_tkeep  in  4  byte enables.
- s_axi_rx_tlast  in  1  last beat of frame.
- s_axi_rx_tvalid  in  1  beat valid. There is no tready; the checker accepts every valid beat.
- o_data_err  out  1  one-cycle pulse per bad beat.
- o_len_err  out  1  one-cycle pulse per length violation.
- o_frame_ok  out  1  one-cycle pulse per good frame.
- o_frame_cnt  out  16  frames completed, good or bad; saturates at 0xFFFF.
- o_err_cnt  out  16  frames with at least one error; saturates at 0xFFFF.
- o_link_ok  out  1  high after P_LOCK_FRAMES consecutive good frames.

## Operation
- A beat is a cycle with s_axi_rx_tvalid=1. Cycles with tvalid=0 change nothing.
- r_beat is a 16-bit index within the frame. The expected data for a beat is {16'd0, r_beat}.
- Because the expected value is the beat index, a single corrupted word produces exactly one data error, not a cascade.
- State machine:
  - S_IDLE: no frame in progress. Any beat starts a frame at index 0. It goes to S_RECV, or finishes immediately if tlast=1.
  - S_RECV: each beat is compared against the expected value and r_beat increments.
  - Beat with tlast and r_beat==P_FRAME_LEN-1: frame complete. Return to S_IDLE.
  - Beat with tlast and r_beat<P_FRAME_LEN-1: short frame. Raise o_len_err and return to S_IDLE.
  - Beat at r_beat==P_FRAME_LEN-1 without tlast: overrun. Raise o_len_err and go to S_DROP.
  - S_DROP: discard beats with no data checks. The tlast beat ends the frame and returns to S_IDLE.
- Frame end (the tlast beat, in any state):
  - o_frame_cnt increments.
  - A frame with any data or length error increments o_err_cnt once and clears the good-frame run. o_link_ok drops.
  - Otherwise o_frame_ok pulses and the run counter increments. o_link_ok sets when the run reaches P_LOCK_FRAMES. The run counter saturates there.
- i_clr zeroes both counters, the run counter and o_link_ok. It does not affect the state machine or the in-frame error flag.
- If i_clr coincides with a frame end, the clear wins: both counters are 0 the next cycle.

## Timing
- All outputs are registered. Pulses and counter updates appear exactly 1 cycle after the triggering beat.
- Counters read their new value 1 cycle after the tlast beat.
- o_data_err and o_len_err can pulse in the same cycle. On an overrun, o_len_err pulses once, 1 cycle after beat index P_FRAME_LEN-1.
- Reset values:
  - state = S_IDLE, r_beat = 0.
  - Every output = 0: o_data_err, o_len_err, o_frame_ok, o_frame_cnt, o_err_cnt, o_link_ok.
- Reset asserted mid-frame abandons the frame without counting it. The next beat is treated as index 0.
- Back-to-back frames need no idle cycle. A beat the cycle after tlast is index 0 of the next frame.

## Configuration
- USER_DATA_CHECK_TKEEP_EN defined: any beat with s_axi_rx_tkeep != 4'b1111 is a data error (o_data_err pulse, frame marked bad), even if tdata matches.
- Undefined: tkeep is ignored entirely.

## Structure
- Package user_data_pkg holds:
  - the state encoding typedef (S_IDLE, S_RECV, S_DROP);
  - P_FRAME_LEN default, shared with the TX generator;
  - the counter width constant (16).
- Sub-module user_sat_cnt: a saturating up-counter with synchronous clear and increment enable. It is instantiated for o_frame_cnt and o_err_cnt.

## Test plan
- Reset, then 3 back-to-back frames of data 0..99 with tlast on beat 99 -> 3 o_frame_ok pulses, o_frame_cnt=3, o_err_cnt=0, o_link_ok rises 1 cycle after the second tlast.
- Frame with beat 50 data 0xFF instead of 0x32 -> one o_data_err pulse, the cycle after that beat only; o_err_cnt=1; o_link_ok=0; the next good frame produces o_frame_ok.
- 99-beat frame (tlast on index 98) -> o_len_err pulse; o_err_cnt+1; no o_frame_ok. A 101-beat frame -> o_len_err after index 99; beat 100 ignored; counted once at its tlast.
- Good frame with random tvalid gaps (about 30% idle) -> o_frame_ok, no errors; counters identical to the gap-free run.
- i_clr on the same cycle as a tlast beat -> o_frame_cnt=0 and o_err_cnt=0 next cycle. i_rst at beat 40 -> all outputs 0; the following full frame is good.
- With USER_DATA_CHECK_TKEEP_EN defined, tkeep=4'b0111 on beat 10 -> o_data_err pulse and frame bad. Without the macro, the same stimulus -> no error.

Source files
------------

// File: rtl/user_data_pkg.sv
// Shared types and constants for the Aurora user-data checker and its TX pattern generator.
package user_data_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } chk_state_e;

  // Beats per frame; the TX generator uses the same value.
  localparam int FRAME_LEN_DEF = 100;

  localparam int CNT_W = 16;

endpackage

// File: rtl/user_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module user_sat_cnt
  import user_data_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/user_data_check.sv
// Receive-side checker for the Aurora 8B/10B user interface: verifies the 0,1,2,... per-frame pattern.
// Build option USER_DATA_CHECK_TKEEP_EN: treat any beat with partial tkeep as a data error.
module user_data_check
  import user_data_pkg::*;
#(
  parameter int P_FRAME_LEN   = FRAME_LEN_DEF,
  parameter int P_LOCK_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [31:0]      s_axi_rx_tdata,
  input  logic [3:0]       s_axi_rx_tkeep,
  input  logic             s_axi_rx_tlast,
  input  logic             s_axi_rx_tvalid,
  output logic             o_data_err,
  output logic             o_len_err,
  output logic             o_frame_ok,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_link_ok
);

  localparam logic [15:0] LAST_IDX = 16'(P_FRAME_LEN - 1);
  localparam logic [7:0]  LOCK_N   = 8'(P_LOCK_FRAMES);

  chk_state_e  state_q;
  logic [15:0] r_beat_q;
  logic        err_q;
  logic [7:0]  run_q;
  logic        data_err_q;
  logic        len_err_q;
  logic        frame_ok_q;
  logic        link_ok_q;

  logic [15:0] idx_d;
  logic        checking;
  logic        data_bad;
  logic        at_last_idx;
  logic        len_bad;
  logic        frame_end;
  logic        frame_bad;
  logic        frame_good_end;
  logic        frame_bad_end;

`ifndef USER_DATA_CHECK_TKEEP_EN
  logic unused_tkeep;
  assign unused_tkeep = &s_axi_rx_tkeep;
`endif

  // A beat in S_IDLE is always index 0, so a frame can start without an idle gap.
  always_comb begin
    idx_d       = (state_q == S_IDLE) ? 16'd0 : r_beat_q;
    checking    = (state_q != S_DROP);
    data_bad    = checking && (s_axi_rx_tdata != {16'd0, idx_d});
`ifdef USER_DATA_CHECK_TKEEP_EN
    data_bad    = data_bad || (checking && (s_axi_rx_tkeep != 4'b1111));
`endif
    at_last_idx = checking && (idx_d == LAST_IDX);
    len_bad     = (checking && s_axi_rx_tlast && !at_last_idx) ||
                  (at_last_idx && !s_axi_rx_tlast);
    frame_end      = s_axi_rx_tvalid && s_axi_rx_tlast;
    frame_bad      = err_q || data_bad || len_bad;
    frame_good_end = frame_end && !frame_bad;
    frame_bad_end  = frame_end && frame_bad;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      r_beat_q   <= '0;
      err_q      <= 1'b0;
      run_q      <= '0;
      data_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      frame_ok_q <= 1'b0;
      link_ok_q  <= 1'b0;
    end else begin
      data_err_q <= s_axi_rx_tvalid && data_bad;
      len_err_q  <= s_axi_rx_tvalid && len_bad;
      frame_ok_q <= frame_good_end;

      if (s_axi_rx_tvalid) begin
        case (state_q)
          S_IDLE, S_RECV: begin
            if (s_axi_rx_tlast) begin
              state_q  <= S_IDLE;
              r_beat_q <= '0;
              err_q    <= 1'b0;
            end else if (at_last_idx) begin
              state_q  <= S_DROP;
              err_q    <= 1'b1;
            end else begin
              state_q  <= S_RECV;
              r_beat_q <= idx_d + 16'd1;
              err_q    <= frame_bad;
            end
          end
          S_DROP: begin
            if (s_axi_rx_tlast) begin
              state_q  <= S_IDLE;
              r_beat_q <= '0;
              err_q    <= 1'b0;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            r_beat_q <= '0;
            err_q    <= 1'b0;
          end
        endcase
      end

      // Clear wins over a coincident frame end.
      if (i_clr) begin
        run_q     <= '0;
        link_ok_q <= 1'b0;
      end else if (frame_bad_end) begin
        run_q     <= '0;
        link_ok_q <= 1'b0;
      end else if (frame_good_end) begin
        if (run_q != LOCK_N) begin
          run_q <= run_q + 8'd1;
        end
        if (run_q >= LOCK_N - 8'd1) begin
          link_ok_q <= 1'b1;
        end
      end
    end
  end

  user_sat_cnt #(.W(CNT_W)) u_frame_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr_i (i_clr),
    .inc_i (frame_end),
    .cnt_o (o_frame_cnt)
  );

  user_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr_i (i_clr),
    .inc_i (frame_bad_end),
    .cnt_o (o_err_cnt)
  );

  assign o_data_err = data_err_q;
  assign o_len_err  = len_err_q;
  assign o_frame_ok = frame_ok_q;
  assign o_link_ok  = link_ok_q;

endmodule

// File: tb/tb_user_data_check.sv
// Directed bench for user_data_check: frame pattern, length errors, clear/reset and tkeep handling.
module tb_user_data_check;

`ifdef USER_DATA_CHECK_TKEEP_EN
  localparam bit KEEP_EN = 1'b1;
`else
  localparam bit KEEP_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clr = 1'b0;
  logic [31:0] s_axi_rx_tdata = '0;
  logic [3:0]  s_axi_rx_tkeep = 4'hF;
  logic        s_axi_rx_tlast = 1'b0;
  logic        s_axi_rx_tvalid = 1'b0;
  logic        o_data_err;
  logic        o_len_err;
  logic        o_frame_ok;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_err_cnt;
  logic        o_link_ok;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ok     = 0;
  int n_derr   = 0;
  int n_lerr   = 0;
  int n_timing = 0;

  user_data_check #(.P_FRAME_LEN(100), .P_LOCK_FRAMES(2)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clr           (i_clr),
    .s_axi_rx_tdata  (s_axi_rx_tdata),
    .s_axi_rx_tkeep  (s_axi_rx_tkeep),
    .s_axi_rx_tlast  (s_axi_rx_tlast),
    .s_axi_rx_tvalid (s_axi_rx_tvalid),
    .o_data_err      (o_data_err),
    .o_len_err       (o_len_err),
    .o_frame_ok      (o_frame_ok),
    .o_frame_cnt     (o_frame_cnt),
    .o_err_cnt       (o_err_cnt),
    .o_link_ok       (o_link_ok)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, when the beat's pulses are visible.
  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic last,
                      input logic clr, input logic exp_d, input logic exp_l, input logic exp_ok);
    s_axi_rx_tdata  = d;
    s_axi_rx_tkeep  = k;
    s_axi_rx_tlast  = last;
    s_axi_rx_tvalid = 1'b1;
    i_clr           = clr;
    @(negedge i_clk);
    if (o_data_err !== exp_d || o_len_err !== exp_l || o_frame_ok !== exp_ok) n_timing++;
    if (o_data_err) n_derr++;
    if (o_len_err)  n_lerr++;
    if (o_frame_ok) n_ok++;
    s_axi_rx_tvalid = 1'b0;
    s_axi_rx_tlast  = 1'b0;
    i_clr           = 1'b0;
  endtask

  task automatic idle();
    s_axi_rx_tvalid = 1'b0;
    s_axi_rx_tlast  = 1'b0;
    @(negedge i_clk);
    if (o_data_err || o_len_err || o_frame_ok) n_timing++;
  endtask

  // Expected pulses come from the frame rules for a 100-beat frame.
  task automatic send_frame(input int n, input int bad_idx, input logic [31:0] bad_val,
                            input int keep_idx, input int gap_pct, input bit with_last,
                            input bit clr_last);
    logic        bad;
    logic [31:0] d;
    logic [3:0]  k;
    logic        last, chk, ed, el, eo;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle();
      d    = (i == bad_idx) ? bad_val : 32'(i);
      k    = (i == keep_idx) ? 4'b0111 : 4'b1111;
      last = with_last && (i == n - 1);
      chk  = (i <= 99);
      ed   = chk && ((d != 32'(i)) || (KEEP_EN && k != 4'b1111));
      el   = chk && ((last && i != 99) || (!last && i == 99));
      bad  = bad | ed | el;
      eo   = last && !bad;
      beat(d, k, last, clr_last && last, ed, el, eo);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_data_err"}, o_data_err, 0);
    check({pfx, "_len_err"}, o_len_err, 0);
    check({pfx, "_frame_ok"}, o_frame_ok, 0);
    check({pfx, "_frame_cnt"}, o_frame_cnt, 0);
    check({pfx, "_err_cnt"}, o_err_cnt, 0);
    check({pfx, "_link_ok"}, o_link_ok, 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check_all_zero("rst");
    i_rst = 1'b0;
    @(negedge i_clk);

    send_frame(100, -1, 0, -1, 0, 1, 0);
    check("f1_cnt", o_frame_cnt, 1);
    check("f1_link", o_link_ok, 0);
    send_frame(100, -1, 0, -1, 0, 1, 0);
    check("f2_link_rise", o_link_ok, 1);
    send_frame(100, -1, 0, -1, 0, 1, 0);
    idle();
    check("f3_cnt", o_frame_cnt, 3);
    check("f3_err", o_err_cnt, 0);
    check("f3_ok_pulses", n_ok, 3);

    send_frame(100, 50, 32'hFF, -1, 0, 1, 0);
    check("bad_derr", n_derr, 1);
    check("bad_err_cnt", o_err_cnt, 1);
    check("bad_link", o_link_ok, 0);
    check("bad_ok_pulses", n_ok, 3);
    send_frame(100, -1, 0, -1, 0, 1, 0);
    check("after_bad_ok", n_ok, 4);
    check("after_bad_link", o_link_ok, 0);
    check("after_bad_cnt", o_frame_cnt, 5);

    send_frame(99, -1, 0, -1, 0, 1, 0);
    check("short_lerr", n_lerr, 1);
    check("short_err_cnt", o_err_cnt, 2);
    check("short_no_ok", n_ok, 4);
    send_frame(101, -1, 0, -1, 0, 1, 0);
    idle();
    check("over_lerr", n_lerr, 2);
    check("over_err_cnt", o_err_cnt, 3);
    check("over_frame_cnt", o_frame_cnt, 7);

    send_frame(100, -1, 0, -1, 30, 1, 0);
    idle();
    check("gap_ok", n_ok, 5);
    check("gap_frame_cnt", o_frame_cnt, 8);
    check("gap_err_cnt", o_err_cnt, 3);
    check("gap_derr", n_derr, 1);
    send_frame(100, -1, 0, -1, 0, 1, 0);
    check("gap_then_link", o_link_ok, 1);

    send_frame(100, -1, 0, -1, 0, 1, 1);
    check("clr_frame_cnt", o_frame_cnt, 0);
    check("clr_err_cnt", o_err_cnt, 0);
    check("clr_link", o_link_ok, 0);

    send_frame(40, -1, 0, -1, 0, 0, 0);
    i_rst = 1'b1;
    #2;
    check_all_zero("midrst");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    send_frame(100, -1, 0, -1, 0, 1, 0);
    check("postrst_cnt", o_frame_cnt, 1);
    check("postrst_err", o_err_cnt, 0);

    send_frame(100, -1, 0, 10, 0, 1, 0);
    idle();
    check("keep_err_cnt", o_err_cnt, KEEP_EN ? 1 : 0);
    check("keep_derr", n_derr, KEEP_EN ? 2 : 1);
    check("keep_link", o_link_ok, KEEP_EN ? 0 : 1);
    check("keep_frame_cnt", o_frame_cnt, 2);

    check("pulse_timing", n_timing, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
